// File: rtl/sdr_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM toggle arbiter.
package sdr_arb_pkg;

   localparam int DEF_ADDR_W = 25;
   localparam int DEF_DATA_W = 64;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/sdr_toggle_arbiter.sv
// Arbitrates two toggle-handshake read requesters onto one toggle-handshake
// SDRAM read port; one transfer outstanding at a time.
module sdr_toggle_arbiter
   import sdr_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIXED_PRIO = PRIO_RR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic              rq0_req,
   input  logic              rq1_req,
   output logic              rq0_ack,
   output logic              rq1_ack,
   output logic [DATA_W-1:0] rq0_data,
   output logic [DATA_W-1:0] rq1_data,
   output logic [ADDR_W-1:0] sdr_addr,
   output logic              sdr_req,
   input  logic              sdr_ack,
   input  logic [DATA_W-1:0] sdr_data,
   output logic              busy,
   output logic              grant
);

   // Handshake: a side is pending while its req differs from the matching ack;
   // the responder completes by making ack equal to req again.

   arb_state_e        state_q, state_d;
   logic              grant_q, grant_d;
   logic              sdr_req_q, sdr_req_d;
   logic [ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
   logic              winner;
   logic              complete;

   logic [1:0]        req_in;
   logic [1:0]        pend;
   logic [1:0]        ack_vec;
   logic [ADDR_W-1:0] addr_in  [2];
   logic [DATA_W-1:0] data_vec [2];

   assign req_in     = {rq1_req, rq0_req};
   assign addr_in[0] = rq0_addr;
   assign addr_in[1] = rq1_addr;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sdr_req_d  = sdr_req_q;
      sdr_addr_d = sdr_addr_q;
      complete   = 1'b0;
      winner     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A stale downstream mismatch (e.g. after reset) blocks issue.
            if ((sdr_req_q == sdr_ack) && (pend != 2'b00)) begin
               if (pend == 2'b11)
                  winner = (FIXED_PRIO == PRIO_FIXED) ? 1'b0 : ~grant_q;
               else
                  winner = pend[1];
               grant_d    = winner;
               sdr_addr_d = addr_in[winner];
               sdr_req_d  = ~sdr_req_q;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (sdr_ack == sdr_req_q) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= 1'b1;
         sdr_req_q  <= 1'b0;
         sdr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sdr_req_q  <= sdr_req_d;
         sdr_addr_q <= sdr_addr_d;
      end
   end

   // Per-requester ack/data slice; only the granted slice moves on completion.
   for (genvar n = 0; n < 2; n++) begin : g_req
      logic              ack_q;
      logic [DATA_W-1:0] data_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            ack_q  <= 1'b0;
            data_q <= '0;
         end else if (complete && (grant_q == 1'(n))) begin
            ack_q  <= ~ack_q;
            data_q <= sdr_data;
         end
      end

      assign pend[n]     = req_in[n] ^ ack_q;
      assign ack_vec[n]  = ack_q;
      assign data_vec[n] = data_q;
   end

   assign rq0_ack  = ack_vec[0];
   assign rq1_ack  = ack_vec[1];
   assign rq0_data = data_vec[0];
   assign rq1_data = data_vec[1];
   assign sdr_req  = sdr_req_q;
   assign sdr_addr = sdr_addr_q;
   assign grant    = grant_q;
   // busy doubles as the FSM state observation point (two states only).
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdr_toggle_arbiter.sv
// Bench for sdr_toggle_arbiter: round-robin (d=0) and fixed-priority (d=1)
// instances driven side by side against a transaction-count reference model.
module tb_sdr_toggle_arbiter;

   localparam int AW = 25;
   localparam int DW = 64;

   logic          clk;
   logic          rst;
   logic          rq0_req  [2];
   logic          rq1_req  [2];
   logic [AW-1:0] rq0_addr [2];
   logic [AW-1:0] rq1_addr [2];
   logic          rq0_ack  [2];
   logic          rq1_ack  [2];
   logic [DW-1:0] rq0_data [2];
   logic [DW-1:0] rq1_data [2];
   logic [AW-1:0] sdr_addr [2];
   logic          sdr_req  [2];
   logic          sdr_ack  [2];
   logic [DW-1:0] sdr_data [2];
   logic          busy     [2];
   logic          grant    [2];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: counts of issued and completed transfers.
   bit            m_busy  [2];
   bit            m_grant [2];
   int            m_issue [2];
   logic [AW-1:0] m_addr  [2];
   int            m_done  [2][2];
   logic [DW-1:0] m_data  [2][2];

   // Environment knobs.
   bit ds_auto;
   int lat_lo, lat_hi;
   int lat [2];
   int rq_pct;
   int remaining [2][2];
   bit rand_addr, viol_en;

   // Observation logs.
   logic glog      [2][64];
   int   glog_n    [2];
   int   issue_cyc [2][64];
   int   cmpl_cyc  [2][64];
   int   cmpl_n    [2];
   logic prev_req  [2];
   logic prev_ack  [2][2];
   logic exp_q[$];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sdr_toggle_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g)) u_dut (
         .clk      (clk),
         .reset    (rst),
         .rq0_addr (rq0_addr[g]),
         .rq1_addr (rq1_addr[g]),
         .rq0_req  (rq0_req[g]),
         .rq1_req  (rq1_req[g]),
         .rq0_ack  (rq0_ack[g]),
         .rq1_ack  (rq1_ack[g]),
         .rq0_data (rq0_data[g]),
         .rq1_data (rq1_data[g]),
         .sdr_addr (sdr_addr[g]),
         .sdr_req  (sdr_req[g]),
         .sdr_ack  (sdr_ack[g]),
         .sdr_data (sdr_data[g]),
         .busy     (busy[g]),
         .grant    (grant[g])
      );
   end

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic get_req(int d, int n);
      return (n == 0) ? rq0_req[d] : rq1_req[d];
   endfunction

   function automatic logic [AW-1:0] get_addr(int d, int n);
      return (n == 0) ? rq0_addr[d] : rq1_addr[d];
   endfunction

   task automatic set_req(int d, int n, logic v);
      if (n == 0) rq0_req[d] = v; else rq1_req[d] = v;
   endtask

   task automatic set_addr(int d, int n, logic [AW-1:0] v);
      if (n == 0) rq0_addr[d] = v; else rq1_addr[d] = v;
   endtask

   function automatic logic obs_ack(int d, int n);
      return (n == 0) ? rq0_ack[d] : rq1_ack[d];
   endfunction

   function automatic logic [DW-1:0] obs_data(int d, int n);
      return (n == 0) ? rq0_data[d] : rq1_data[d];
   endfunction

   function automatic bit m_ack(int d, int n);
      return (m_done[d][n] % 2) == 1;
   endfunction

   function automatic bit all_done();
      bit r = 1'b1;
      for (int d = 0; d < 2; d++)
         for (int n = 0; n < 2; n++)
            if (remaining[d][n] != 0 || m_busy[d] || (get_req(d, n) != m_ack(d, n))) r = 1'b0;
      return r;
   endfunction

   // ---------------- reference model ----------------
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_busy[d]  = 1'b0;
            m_grant[d] = 1'b1;
            m_issue[d] = 0;
            m_addr[d]  = '0;
            for (int n = 0; n < 2; n++) begin
               m_done[d][n] = 0;
               m_data[d][n] = '0;
            end
         end else if (!m_busy[d]) begin
            if ((m_issue[d] % 2) == int'(sdr_ack[d])) begin
               bit p0, p1, w;
               p0 = get_req(d, 0) != m_ack(d, 0);
               p1 = get_req(d, 1) != m_ack(d, 1);
               if (p0 || p1) begin
                  if (p0 && p1) w = (d == 1) ? 1'b0 : !m_grant[d];
                  else          w = p0 ? 1'b0 : 1'b1;
                  m_issue[d]++;
                  m_addr[d]  = get_addr(d, int'(w));
                  m_grant[d] = w;
                  m_busy[d]  = 1'b1;
               end
            end
         end else if (int'(sdr_ack[d]) == (m_issue[d] % 2)) begin
            m_done[d][int'(m_grant[d])]++;
            m_data[d][int'(m_grant[d])] = sdr_data[d];
            m_busy[d] = 1'b0;
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic compare_all();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d sdr_req", d), 64'(sdr_req[d]), 64'(m_issue[d] % 2));
         check($sformatf("d%0d sdr_addr", d), 64'(sdr_addr[d]), 64'(m_addr[d]));
         check($sformatf("d%0d busy", d), 64'(busy[d]), 64'(m_busy[d]));
         check($sformatf("d%0d grant", d), 64'(grant[d]), 64'(m_grant[d]));
         for (int n = 0; n < 2; n++) begin
            check($sformatf("d%0d rq%0d_ack", d, n), 64'(obs_ack(d, n)), 64'(m_ack(d, n)));
            check($sformatf("d%0d rq%0d_data", d, n), obs_data(d, n), m_data[d][n]);
         end
      end
   endtask

   task automatic observe_log();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            prev_req[d]    = 1'b0;
            prev_ack[d][0] = 1'b0;
            prev_ack[d][1] = 1'b0;
         end else begin
            if (sdr_req[d] != prev_req[d] && glog_n[d] < 64) begin
               glog[d][glog_n[d]]      = grant[d];
               issue_cyc[d][glog_n[d]] = cyc;
               glog_n[d]++;
            end
            for (int n = 0; n < 2; n++)
               if (obs_ack(d, n) != prev_ack[d][n] && cmpl_n[d] < 64) begin
                  cmpl_cyc[d][cmpl_n[d]] = cyc;
                  cmpl_n[d]++;
               end
            prev_req[d]    = sdr_req[d];
            prev_ack[d][0] = rq0_ack[d];
            prev_ack[d][1] = rq1_ack[d];
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic env_drive();
      for (int d = 0; d < 2; d++) begin
         if (ds_auto && (sdr_req[d] != sdr_ack[d])) begin
            if (lat[d] < 0) lat[d] = $urandom_range(lat_hi, lat_lo);
            if (lat[d] == 0) begin
               sdr_ack[d]  = sdr_req[d];
               sdr_data[d] = {$urandom, $urandom};
               lat[d]      = -1;
            end else begin
               lat[d]--;
            end
         end
         for (int n = 0; n < 2; n++) begin
            bit pend;
            pend = get_req(d, n) != m_ack(d, n);
            if (rand_addr) set_addr(d, n, AW'({$urandom, $urandom}));
            if (!pend && remaining[d][n] > 0 && $urandom_range(99, 0) < rq_pct) begin
               set_req(d, n, !get_req(d, n));
               remaining[d][n]--;
            end else if (pend && viol_en && $urandom_range(199, 0) == 0) begin
               set_req(d, n, !get_req(d, n));
            end
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      observe_log();
      compare_all();
      env_drive();
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      ds_auto = 1'b0;
      rq_pct  = 0;
      viol_en = 1'b0;
      rand_addr = 1'b0;
      for (int d = 0; d < 2; d++) begin
         rq0_req[d] = 1'b0;  rq1_req[d] = 1'b0;
         rq0_addr[d] = '0;   rq1_addr[d] = '0;
         sdr_ack[d] = 1'b0;  sdr_data[d] = '0;
         lat[d] = -1;
         remaining[d][0] = 0; remaining[d][1] = 0;
      end
      cycle();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         glog_n[d] = 0;
         cmpl_n[d] = 0;
      end
   endtask

   // ---------------- tests ----------------
   initial begin
      lat_lo = 0; lat_hi = 0;
      do_reset();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d reset sdr_req", d), 64'(sdr_req[d]), 64'd0);
         check($sformatf("d%0d reset sdr_addr", d), 64'(sdr_addr[d]), 64'd0);
         check($sformatf("d%0d reset acks", d), 64'({rq1_ack[d], rq0_ack[d]}), 64'd0);
         check($sformatf("d%0d reset data0", d), rq0_data[d], 64'd0);
         check($sformatf("d%0d reset data1", d), rq1_data[d], 64'd0);
         check($sformatf("d%0d reset grant", d), 64'(grant[d]), 64'd1);
         check($sformatf("d%0d reset busy", d), 64'(busy[d]), 64'd0);
      end

      // Single read.
      for (int d = 0; d < 2; d++) begin
         rq0_addr[d] = 25'h0123456;
         rq0_req[d]  = 1'b1;
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d single sdr_req", d), 64'(sdr_req[d]), 64'd1);
         check($sformatf("d%0d single sdr_addr", d), 64'(sdr_addr[d]), 64'h0123456);
      end
      repeat (4) cycle();
      for (int d = 0; d < 2; d++) begin
         sdr_ack[d]  = 1'b1;
         sdr_data[d] = 64'hDEADBEEF_CAFEF00D;
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d single rq0_data", d), rq0_data[d], 64'hDEADBEEF_CAFEF00D);
         check($sformatf("d%0d single rq0_ack", d), 64'(rq0_ack[d]), 64'd1);
         check($sformatf("d%0d single rq1_ack", d), 64'(rq1_ack[d]), 64'd0);
      end

      // Tie: four continuous requests per requester on both instances.
      do_reset();
      ds_auto = 1'b1; lat_lo = 2; lat_hi = 2; rq_pct = 100; rand_addr = 1'b1;
      for (int d = 0; d < 2; d++) begin
         remaining[d][0] = 4; remaining[d][1] = 4;
      end
      env_drive();
      for (int i = 0; i < 300 && !all_done(); i++) cycle();
      check("tie finished", 64'(all_done()), 64'd1);
      for (int d = 0; d < 2; d++) begin
         exp_q.delete();
         for (int i = 0; i < 8; i++)
            exp_q.push_back((d == 0) ? logic'(i % 2) : logic'(i >= 4));
         check($sformatf("d%0d tie grant count", d), 64'(glog_n[d]), 64'd8);
         for (int i = 0; i < 8 && i < glog_n[d]; i++)
            check($sformatf("d%0d tie grant #%0d", d, i), 64'(glog[d][i]), 64'(exp_q.pop_front()));
      end

      // Address hold.
      do_reset();
      for (int d = 0; d < 2; d++) begin
         rq1_addr[d] = 25'h10;
         rq1_req[d]  = 1'b1;
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d hold grant", d), 64'(grant[d]), 64'd1);
         rq1_addr[d] = 25'h20;
      end
      repeat (3) begin
         cycle();
         for (int d = 0; d < 2; d++)
            check($sformatf("d%0d hold sdr_addr", d), 64'(sdr_addr[d]), 64'h10);
      end
      for (int d = 0; d < 2; d++) begin
         sdr_ack[d]  = 1'b1;
         sdr_data[d] = {$urandom, $urandom};
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d hold rq1_ack", d), 64'(rq1_ack[d]), 64'd1);
         check($sformatf("d%0d hold sdr_addr end", d), 64'(sdr_addr[d]), 64'h10);
      end

      // Reset in the middle of a transfer, with the downstream ack landing on the reset edge.
      do_reset();
      for (int d = 0; d < 2; d++) rq0_req[d] = 1'b1;
      cycle();
      cycle();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         sdr_ack[d] = 1'b1;
         rq0_req[d] = 1'b0;
         rq1_req[d] = 1'b0;
      end
      cycle();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) rq1_req[d] = 1'b1;
      repeat (3) begin
         cycle();
         for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d stale sdr_req", d), 64'(sdr_req[d]), 64'd0);
            check($sformatf("d%0d stale busy", d), 64'(busy[d]), 64'd0);
            check($sformatf("d%0d stale acks", d), 64'({rq1_ack[d], rq0_ack[d]}), 64'd0);
         end
      end
      for (int d = 0; d < 2; d++) sdr_ack[d] = 1'b0;
      cycle();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d absorb sdr_req", d), 64'(sdr_req[d]), 64'd1);
         check($sformatf("d%0d absorb grant", d), 64'(grant[d]), 64'd1);
         sdr_ack[d] = 1'b1;
      end
      cycle();
      for (int d = 0; d < 2; d++)
         check($sformatf("d%0d absorb rq1_ack", d), 64'(rq1_ack[d]), 64'd1);

      // Back-to-back: rq0 re-requests on the completion edge.
      do_reset();
      ds_auto = 1'b1; lat_lo = 1; lat_hi = 1; rq_pct = 100;
      for (int d = 0; d < 2; d++) remaining[d][0] = 2;
      env_drive();
      for (int i = 0; i < 60 && !all_done(); i++) cycle();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d b2b issues", d), 64'(glog_n[d]), 64'd2);
         check($sformatf("d%0d b2b completions", d), 64'(cmpl_n[d]), 64'd2);
         if (glog_n[d] >= 2 && cmpl_n[d] >= 1)
            check($sformatf("d%0d b2b gap", d), 64'(issue_cyc[d][1] - cmpl_cyc[d][0]), 64'd1);
      end

      // Randomized traffic with occasional resets and protocol violations.
      do_reset();
      ds_auto = 1'b1; lat_lo = 0; lat_hi = 4; rq_pct = 30; rand_addr = 1'b1; viol_en = 1'b1;
      for (int d = 0; d < 2; d++) begin
         remaining[d][0] = 1000000; remaining[d][1] = 1000000;
      end
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(299, 0) == 0) begin
            rst = 1'b1;
            for (int d = 0; d < 2; d++) begin
               rq0_req[d] = 1'b0;
               rq1_req[d] = 1'b0;
            end
            cycle();
            rst = 1'b0;
         end else begin
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
